// File: rtl/circle_octant_if.sv
// Command/status bundle between a draw requester and the circle octant engine.
// The engine side takes the slave modport; the requester side takes master.
interface circle_octant_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int RW = 7,
  parameter int CW = 3
);
  logic          start;
  logic          clear;
  logic [XW-1:0] centre_x;
  logic [YW-1:0] centre_y;
  logic [RW-1:0] radius;
  logic [CW-1:0] colour;
  logic          busy;
  logic          done;
  logic          plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  modport master (
    output start, clear, centre_x, centre_y, radius, colour,
    input  busy, done, plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  start, clear, centre_x, centre_y, radius, colour,
    output busy, done, plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/circle_octant_engine.sv
// Midpoint-circle draw engine: optional raster clear, then one pixel write
// per cycle over all eight octants, with off-screen points suppressed.
module circle_octant_engine #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 7,
  parameter int CW       = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int CLEAR_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  circle_octant_if.slave  bus
);

  localparam int MW  = (XW > YW) ? XW : YW;
  localparam int SW  = ((MW > RW) ? MW : RW) + 2;
  localparam int CRW = RW + 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_INIT  = 3'd2;
  localparam logic [2:0] ST_OCT   = 3'd3;
  localparam logic [2:0] ST_STEP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic signed [SW-1:0]  S_ZERO     = {SW{1'b0}};
  localparam logic signed [SW-1:0]  S_ONE      = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0]  S_XMAX     = SW'(X_MAX);
  localparam logic signed [SW-1:0]  S_YMAX     = SW'(Y_MAX);
  localparam logic signed [CRW-1:0] CRIT_ONE   = {{(CRW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0]         CLR_X_LAST = XW'(X_MAX);
  localparam logic [YW-1:0]         CLR_Y_LAST = YW'(Y_MAX);

  logic [2:0]            r_state;
  logic [XW-1:0]         r_cx;
  logic [YW-1:0]         r_cy;
  logic [RW-1:0]         r_rad;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_ox;
  logic [RW-1:0]         r_oy;
  logic signed [CRW-1:0] r_crit;
  logic [2:0]            r_k;
  logic [XW-1:0]         r_clr_x;
  logic [YW-1:0]         r_clr_y;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_plot;
  logic [XW-1:0]         r_vga_x;
  logic [YW-1:0]         r_vga_y;
  logic [CW-1:0]         r_vga_col;

  logic signed [SW-1:0]  w_cxs, w_cys, w_oxs, w_oys;
  logic signed [SW-1:0]  w_dx, w_dy, w_px, w_py;
  logic                  w_vis;
  logic signed [SW-1:0]  w_oy1, w_ox_dec, w_ox_next, w_delta;
  logic                  w_crit_pos;
  logic signed [CRW-1:0] w_crit_next;
  logic signed [CRW-1:0] w_rad_c;

  // All arithmetic is done signed and two bits wider than any operand so it never wraps.
  assign w_cxs = $signed({{(SW-XW){1'b0}}, r_cx});
  assign w_cys = $signed({{(SW-YW){1'b0}}, r_cy});
  assign w_oxs = $signed({{(SW-RW){1'b0}}, r_ox});
  assign w_oys = $signed({{(SW-RW){1'b0}}, r_oy});
  assign w_rad_c = $signed({{(CRW-RW){1'b0}}, r_rad});

  // Octant offset selection for point k.
  always_comb begin
    w_dx = S_ZERO;
    w_dy = S_ZERO;
    case (r_k)
      3'd0: begin w_dx = w_oxs;          w_dy = w_oys;          end
      3'd1: begin w_dx = w_oys;          w_dy = w_oxs;          end
      3'd2: begin w_dx = S_ZERO - w_oys; w_dy = w_oxs;          end
      3'd3: begin w_dx = S_ZERO - w_oxs; w_dy = w_oys;          end
      3'd4: begin w_dx = S_ZERO - w_oxs; w_dy = S_ZERO - w_oys; end
      3'd5: begin w_dx = S_ZERO - w_oys; w_dy = S_ZERO - w_oxs; end
      3'd6: begin w_dx = w_oys;          w_dy = S_ZERO - w_oxs; end
      3'd7: begin w_dx = w_oxs;          w_dy = S_ZERO - w_oys; end
      default: begin w_dx = S_ZERO;      w_dy = S_ZERO;         end
    endcase
  end

  assign w_px  = w_cxs + w_dx;
  assign w_py  = w_cys + w_dy;
  assign w_vis = (w_px >= S_ZERO) && (w_px <= S_XMAX) &&
                 (w_py >= S_ZERO) && (w_py <= S_YMAX);

  // ox can go to -1 for radius 0, so the loop-exit compare must stay signed.
  assign w_oy1       = w_oys + S_ONE;
  assign w_ox_dec    = w_oxs - S_ONE;
  assign w_crit_pos  = (r_crit > $signed({CRW{1'b0}}));
  assign w_ox_next   = w_crit_pos ? w_ox_dec : w_oxs;
  assign w_delta     = w_crit_pos ? (w_oy1 - w_ox_dec) : w_oy1;
  assign w_crit_next = r_crit + CRW'(w_delta) + CRW'(w_delta) + CRIT_ONE;

  // Control FSM with registered pixel and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cx      <= '0;
      r_cy      <= '0;
      r_rad     <= '0;
      r_col     <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_crit    <= '0;
      r_k       <= 3'd0;
      r_clr_x   <= '0;
      r_clr_y   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_plot    <= 1'b0;
      r_vga_x   <= '0;
      r_vga_y   <= '0;
      r_vga_col <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_plot <= 1'b0;
          r_done <= 1'b0;
          if (bus.start) begin
            r_cx    <= bus.centre_x;
            r_cy    <= bus.centre_y;
            r_rad   <= bus.radius;
            r_col   <= bus.colour;
            r_clr_x <= '0;
            r_clr_y <= '0;
            r_busy  <= 1'b1;
            r_state <= (bus.clear && (CLEAR_EN != 0)) ? ST_CLEAR : ST_INIT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_plot    <= 1'b1;
          r_vga_x   <= r_clr_x;
          r_vga_y   <= r_clr_y;
          r_vga_col <= '0;
          if (r_clr_x == CLR_X_LAST) begin
            r_clr_x <= '0;
            if (r_clr_y == CLR_Y_LAST) begin
              r_state <= ST_INIT;
            end else begin
              r_clr_y <= r_clr_y + {{(YW-1){1'b0}}, 1'b1};
            end
          end else begin
            r_clr_x <= r_clr_x + {{(XW-1){1'b0}}, 1'b1};
          end
        end
        ST_INIT: begin
          r_plot  <= 1'b0;
          r_ox    <= r_rad;
          r_oy    <= '0;
          r_crit  <= CRIT_ONE - w_rad_c;
          r_k     <= 3'd0;
          r_state <= ST_OCT;
        end
        ST_OCT: begin
          r_plot <= w_vis;
          if (w_vis) begin
            r_vga_x   <= w_px[XW-1:0];
            r_vga_y   <= w_py[YW-1:0];
            r_vga_col <= r_col;
          end else begin
            r_vga_col <= r_vga_col;
          end
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) begin
            r_state <= ST_STEP;
          end else begin
            r_state <= ST_OCT;
          end
        end
        ST_STEP: begin
          r_plot <= 1'b0;
          r_oy   <= w_oy1[RW-1:0];
          r_ox   <= w_ox_next[RW-1:0];
          r_crit <= w_crit_next;
          r_k    <= 3'd0;
          if (w_oy1 <= w_ox_next) begin
            r_state <= ST_OCT;
          end else begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_plot <= 1'b0;
          if (!bus.start) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else begin
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_plot  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.plot       = r_plot;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_col;

endmodule

// File: tb/tb_circle_octant_engine.sv
// Self-checking bench: three engines (full screen, 4x2 screen, 4x2 with clear
// disabled) share one command stream and are compared to a pixel-list model.
module tb_circle_octant_engine;

  typedef logic [17:0] pix_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  circle_octant_if bus0 ();
  circle_octant_if bus1 ();
  circle_octant_if bus2 ();

  circle_octant_engine #(.X_MAX(159), .Y_MAX(119), .CLEAR_EN(1)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0));
  circle_octant_engine #(.X_MAX(3), .Y_MAX(1), .CLEAR_EN(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1));
  circle_octant_engine #(.X_MAX(3), .Y_MAX(1), .CLEAR_EN(0)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .bus(bus2));

  pix_t obs0[$], obs1[$], obs2[$], exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Pixel monitors: capture every write strobe.
  always @(negedge clk) begin
    if (bus0.plot) obs0.push_back({bus0.vga_x, bus0.vga_y, bus0.vga_colour});
    if (bus1.plot) obs1.push_back({bus1.vga_x, bus1.vga_y, bus1.vga_colour});
    if (bus2.plot) obs2.push_back({bus2.vga_x, bus2.vga_y, bus2.vga_colour});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit c, input int cx, input int cy, input int r, input int col);
    bus0.start = s; bus0.clear = c; bus0.centre_x = 8'(cx); bus0.centre_y = 7'(cy);
    bus0.radius = 7'(r); bus0.colour = 3'(col);
    bus1.start = s; bus1.clear = c; bus1.centre_x = 8'(cx); bus1.centre_y = 7'(cy);
    bus1.radius = 7'(r); bus1.colour = 3'(col);
    bus2.start = s; bus2.clear = c; bus2.centre_x = 8'(cx); bus2.centre_y = 7'(cy);
    bus2.radius = 7'(r); bus2.colour = 3'(col);
  endtask

  // Reference: expected pixel list and cycles from capture to done.
  task automatic build_model(input int cx, input int cy, input int r, input int col, input bit clr,
                             input int xmax, input int ymax, input bit clr_en, output int cyc);
    int ox, oy, crit, px, py;
    exp_q.delete();
    cyc = 1;
    if (clr && clr_en) begin
      for (int y = 0; y <= ymax; y++)
        for (int x = 0; x <= xmax; x++)
          exp_q.push_back({8'(x), 7'(y), 3'd0});
      cyc += (xmax + 1) * (ymax + 1);
    end
    ox = r; oy = 0; crit = 1 - r;
    do begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin px = cx + ox; py = cy + oy; end
          1: begin px = cx + oy; py = cy + ox; end
          2: begin px = cx - oy; py = cy + ox; end
          3: begin px = cx - ox; py = cy + oy; end
          4: begin px = cx - ox; py = cy - oy; end
          5: begin px = cx - oy; py = cy - ox; end
          6: begin px = cx + oy; py = cy - ox; end
          default: begin px = cx + ox; py = cy - oy; end
        endcase
        if (px >= 0 && px <= xmax && py >= 0 && py <= ymax)
          exp_q.push_back({8'(px), 7'(py), 3'(col)});
      end
      cyc += 9;
      oy = oy + 1;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox = ox - 1;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask

  task automatic compare_inst(input int idx, input string name, input int cyc_want, input int cyc_got);
    pix_t got[$];
    int bad;
    case (idx)
      0: got = obs0;
      1: got = obs1;
      default: got = obs2;
    endcase
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    check_val({name, "_count"}, got.size(), exp_q.size());
    check_val({name, "_pixels_bad"}, bad, 0);
    check_val({name, "_done_cycle"}, cyc_got, cyc_want);
  endtask

  // Issue one command (start held high), then verify DONE hold and release.
  task automatic run_cmd(input string name, input int cx, input int cy, input int r,
                         input int col, input bit clr, input bit scramble);
    int t[3];
    int cyc, budget, held;
    obs0.delete(); obs1.delete(); obs2.delete();
    t[0] = -1; t[1] = -1; t[2] = -1;
    budget = (clr ? 19200 : 0) + 9 * (r + 2) + 40;
    drive(1'b1, clr, cx, cy, r, col);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (scramble)
        drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 127), $urandom_range(0, 7));
      if (bus0.done && t[0] < 0) t[0] = n;
      if (bus1.done && t[1] < 0) t[1] = n;
      if (bus2.done && t[2] < 0) t[2] = n;
      if (t[0] >= 0 && t[1] >= 0 && t[2] >= 0) break;
    end
    build_model(cx, cy, r, col, clr, 159, 119, 1'b1, cyc);
    compare_inst(0, {name, "_full"}, cyc, t[0]);
    build_model(cx, cy, r, col, clr, 3, 1, 1'b1, cyc);
    compare_inst(1, {name, "_small"}, cyc, t[1]);
    build_model(cx, cy, r, col, clr, 3, 1, 1'b0, cyc);
    compare_inst(2, {name, "_noclr"}, cyc, t[2]);
    held = obs0.size() + obs1.size() + obs2.size();
    for (int n = 0; n < 5; n++) tick();
    check_val({name, "_done_held"}, {bus2.done, bus1.done, bus0.done}, 3'b111);
    check_val({name, "_no_retrigger"}, obs0.size() + obs1.size() + obs2.size(), held);
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    tick();
    check_val({name, "_released"},
              {bus0.done, bus0.busy, bus1.done, bus1.busy, bus2.done, bus2.busy}, 6'b0);
  endtask

  initial begin
    pix_t first;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (3) tick();
    check_val("reset_full",  {bus0.busy, bus0.done, bus0.plot, bus0.vga_x, bus0.vga_y, bus0.vga_colour}, 0);
    check_val("reset_small", {bus1.busy, bus1.done, bus1.plot, bus1.vga_x, bus1.vga_y, bus1.vga_colour}, 0);
    check_val("reset_noclr", {bus2.busy, bus2.done, bus2.plot, bus2.vga_x, bus2.vga_y, bus2.vga_colour}, 0);
    rst = 1'b0;
    tick();

    // Reset partway through a screen clear.
    obs0.delete();
    drive(1'b1, 1'b1, 50, 50, 20, 7);
    repeat (30) tick();
    check_val("t1_clearing", (obs0.size() > 0) ? 1 : 0, 1);
    check_val("t1_busy_before", bus0.busy, 1);
    rst = 1'b1;
    tick();
    check_val("t1_rst_out", {bus0.plot, bus0.busy, bus0.done, bus1.plot, bus1.busy, bus2.plot, bus2.busy}, 0);
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    rst = 1'b0;
    obs0.delete(); obs1.delete(); obs2.delete();
    repeat (20) tick();
    check_val("t1_no_writes", obs0.size() + obs1.size() + obs2.size(), 0);
    check_val("t1_idle", {bus0.busy, bus0.done}, 0);

    run_cmd("t2_r0", 80, 60, 0, 6, 1'b0, 1'b0);

    run_cmd("t3_r1", 10, 10, 1, 5, 1'b0, 1'b1);
    first = (obs0.size() > 0) ? obs0[0] : '0;
    check_val("t3_first_pixel", first, {8'd11, 7'd10, 3'd5});

    run_cmd("t4_clip", 0, 0, 5, 3, 1'b0, 1'b1);
    run_cmd("t5_clear", 1, 0, 2, 4, 1'b1, 1'b1);
    run_cmd("t6_next", 2, 1, 1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++)
      run_cmd("rand", $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 40),
              $urandom_range(0, 7), 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
